// File: rtl/softmax_div_seq_if.sv
// Operand/result channel bundle for the sequential softmax divider.
// Handshake: a beat transfers on a rising edge where valid=1 and ready=1; valid and its data are held until that edge.
`timescale 1ns/1ps
interface softmax_div_seq_if #(
  parameter int QW = 8,
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] in_x;
  logic [DW-1:0] in_y;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] out_q;
  logic [DW-1:0] out_r;
  logic          out_dz;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_q, out_r, out_dz
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_q, out_r, out_dz
  );
endinterface

// File: rtl/softmax_div_seq.sv
// Restoring divider producing one quotient bit per CALC cycle for softmax normalisation.
// The numerator is pre-shifted left by DW+1-QW so the quotient is a fraction of the divisor.
`timescale 1ns/1ps
module softmax_div_seq #(
  parameter int QW = 8,
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               rst,
  softmax_div_seq_if.slave   io,
  output logic               busy,
  output logic [1:0]         state_dbg
);
  localparam int SH = DW + 1 - QW;
  localparam int KW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [DW:0]   r;
  logic [DW:0]   r_sub;
  logic [DW-1:0] y;
  logic [QW-1:0] q;
  logic [KW-1:0] k;
  logic          dz;
  logic          ge;
  logic          accept;

  assign accept = (state == IDLE) && io.in_valid;
  assign ge     = (r >= {1'b0, y});
  assign r_sub  = ge ? (r - {1'b0, y}) : r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (io.in_valid) state_nx = CALC;
      CALC:    if (k == '0) state_nx = DONE;
      DONE:    if (io.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    io.in_ready  = (state == IDLE);
    io.out_valid = (state == DONE);
    io.out_q     = (state == DONE) ? q : '0;
    io.out_r     = (state == DONE) ? r[DW:1] : '0;
    io.out_dz    = (state == DONE) ? dz : 1'b0;
    busy         = (state != IDLE);
    state_dbg    = state;
  end

  // Datapath only moves on accept and during CALC, so results hold through any DONE stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r  <= '0;
      y  <= '0;
      q  <= '0;
      k  <= '0;
      dz <= 1'b0;
    end else if (accept) begin
      y  <= io.in_y;
      r  <= {io.in_x, {SH{1'b0}}};
      q  <= '0;
      k  <= KW'(QW - 1);
      dz <= (io.in_y == '0);
    end else if (state == CALC) begin
      q[k] <= ge;
      r    <= {r_sub[DW-1:0], 1'b0};
      k    <= k - 1'b1;
    end
  end
endmodule

// File: tb/tb_softmax_div_seq.sv
// Directed and randomised checks of the sequential softmax divider against hand values and a bit model.
`timescale 1ns/1ps
module tb_softmax_div_seq;
  localparam int QW = 8;
  localparam int DW = 32;
  localparam int SH = DW + 1 - QW;
  localparam int RW = QW + DW + 1;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [1:0] state_dbg;

  softmax_div_seq_if #(.QW(QW), .DW(DW)) ifc ();

  softmax_div_seq #(.QW(QW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (ifc.slave),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  logic [RW-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [RW-1:0] model(input logic [QW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0]   rm;
    logic [QW-1:0] qm;
    rm = {x, {SH{1'b0}}};
    qm = '0;
    for (int i = QW - 1; i >= 0; i--) begin
      if (rm >= {1'b0, y}) begin
        qm[i] = 1'b1;
        rm    = rm - {1'b0, y};
      end
      rm = rm << 1;
    end
    return {qm, rm[DW:1], (y == '0)};
  endfunction

  // driver: accept one request, scramble the inputs, and measure edges to out_valid
  task automatic start_req(input logic [QW-1:0] x, input logic [DW-1:0] y, output int lat);
    ifc.in_x     = x;
    ifc.in_y     = y;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    ifc.in_x     = ~x;
    ifc.in_y     = ~y;
    lat = 0;
    while (!ifc.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_one(input string tag, input logic [QW-1:0] x, input logic [DW-1:0] y,
                         input logic [QW-1:0] eq, input logic [DW-1:0] er, input logic edz);
    int lat;
    start_req(x, y, lat);
    // DONE is entered on the QW-th edge after the accept edge (QW+1 edges counting the accept)
    check({tag, "_lat"}, 64'(lat), 64'(QW));
    check({tag, "_q"},   64'(ifc.out_q), 64'(eq));
    check({tag, "_r"},   64'(ifc.out_r), 64'(er));
    check({tag, "_dz"},  64'(ifc.out_dz), 64'(edz));
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    check({tag, "_vld_drop"}, 64'(ifc.out_valid), 64'd0);
    check({tag, "_rdy_back"}, 64'(ifc.in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int n;
    int vld_seen;
    int acc;
    int hs;
    logic [QW-1:0] rx;
    logic [DW-1:0] ry;
    logic [RW-1:0] got;
    logic [RW-1:0] want;
    int sel;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_x      = '0;
    ifc.in_y      = '0;
    ifc.out_ready = 1'b0;
    tick();
    tick();
    check("rst_vld",  64'(ifc.out_valid), 64'd0);
    check("rst_q",    64'(ifc.out_q), 64'd0);
    check("rst_r",    64'(ifc.out_r), 64'd0);
    check("rst_dz",   64'(ifc.out_dz), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_rdy",  64'(ifc.in_ready), 64'd1);

    run_one("one",  8'h01, 32'h0200_0000, 8'h80, 32'h0, 1'b0);
    run_one("three", 8'h03, 32'h0400_0000, 8'hC0, 32'h0, 1'b0);
    run_one("zero_x", 8'h00, 32'd5, 8'h00, 32'h0, 1'b0);
    run_one("dz",   8'hAB, 32'h0, 8'hFF, 32'h0, 1'b1);
    run_one("third", 8'h02, 32'h0300_0000, 8'hAA, 32'h0200_0000, 1'b0);

    // stall in DONE while a competing request is offered
    start_req(8'h02, 32'h0300_0000, lat);
    check("stall_lat", 64'(lat), 64'(QW));
    ifc.in_valid = 1'b1;
    ifc.in_x     = 8'h11;
    ifc.in_y     = 32'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_vld",  64'(ifc.out_valid), 64'd1);
      check("stall_q",    64'(ifc.out_q), 64'hAA);
      check("stall_r",    64'(ifc.out_r), 64'h0200_0000);
      check("stall_dz",   64'(ifc.out_dz), 64'd0);
      check("stall_rdy",  64'(ifc.in_ready), 64'd0);
      check("stall_busy", 64'(busy), 64'd1);
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    check("stall_rel_vld", 64'(ifc.out_valid), 64'd0);
    check("stall_rel_rdy", 64'(ifc.in_ready), 64'd1);

    // reset during the 4th CALC cycle
    ifc.in_x     = 8'h55;
    ifc.in_y     = 32'd3;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rdy",  64'(ifc.in_ready), 64'd1);
    vld_seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (ifc.out_valid) vld_seen++;
      tick();
    end
    check("mid_rst_no_vld", 64'(vld_seen), 64'd0);
    run_one("after_rst", 8'h01, 32'h0200_0000, 8'h80, 32'h0, 1'b0);

    // back-to-back random requests through the scoreboard
    acc = 0;
    hs  = 0;
    for (int it = 0; it < 1000; it++) begin
      rx  = QW'($urandom_range(0, 255));
      sel = $urandom_range(0, 3);
      if (sel == 0)      ry = '0;
      else if (sel == 1) ry = DW'($urandom_range(1, 255));
      else               ry = DW'($urandom);
      ifc.in_x     = rx;
      ifc.in_y     = ry;
      ifc.in_valid = 1'b1;
      n = 0;
      while (!ifc.in_ready && n < 40) begin
        tick();
        n++;
      end
      check("rnd_rdy_tmo", 64'(ifc.in_ready), 64'd1);
      if (ifc.in_ready) begin
        exp_q.push_back(model(rx, ry));
        acc++;
      end
      tick();
      ifc.in_valid = 1'b0;
      ifc.in_x     = QW'($urandom);
      ifc.in_y     = DW'($urandom);
      n = 0;
      while (!ifc.out_valid && n < 40) begin
        tick();
        n++;
      end
      check("rnd_vld_tmo", 64'(ifc.out_valid), 64'd1);
      if (ifc.out_valid) begin
        got = {ifc.out_q, ifc.out_r, ifc.out_dz};
        if (exp_q.size() > 0) want = exp_q.pop_front();
        else want = '0;
        check("rnd_result", 64'(got), 64'(want));
        ifc.out_ready = 1'b1;
        hs++;
        tick();
        ifc.out_ready = 1'b0;
      end
    end
    check("rnd_handshakes", 64'(hs), 64'(acc));
    check("rnd_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
